// File: rtl/integer_datapath_pipe_pkg.sv
// Shared definitions for the 2-stage integer datapath: ALU opcode encodings.
package integer_dp_pkg;

  localparam int unsigned OP_W = 4;

  typedef logic [OP_W-1:0] alu_op_t;

  localparam alu_op_t OP_PASS_S = 4'h0;
  localparam alu_op_t OP_PASS_R = 4'h1;
  localparam alu_op_t OP_ADD    = 4'h2;
  localparam alu_op_t OP_SUB    = 4'h3;
  localparam alu_op_t OP_INC    = 4'h4;
  localparam alu_op_t OP_DEC    = 4'h5;
  localparam alu_op_t OP_AND    = 4'h6;
  localparam alu_op_t OP_OR     = 4'h7;
  localparam alu_op_t OP_XOR    = 4'h8;
  localparam alu_op_t OP_NOT    = 4'h9;
  localparam alu_op_t OP_SHL    = 4'hA;
  localparam alu_op_t OP_SHR    = 4'hB;
  localparam alu_op_t OP_ASR    = 4'hC;

endpackage

// File: rtl/integer_datapath_pipe_if.sv
// Issue/result bundle between the control unit (master) and the datapath (slave).
interface integer_datapath_pipe_if
  import integer_dp_pkg::*;
#(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 8
);

  localparam int unsigned AW = $clog2(NREG);

  // Issue side
  logic          In_Valid;
  logic          W_En;
  logic [AW-1:0] W_Adr;
  logic [AW-1:0] R_Adr;
  logic [AW-1:0] S_Adr;
  logic          S_Sel;
  logic [DW-1:0] DS;
  alu_op_t       ALU_OP;

  // Retire side
  logic          Out_Valid;
  logic [DW-1:0] Alu_Out;
  logic [DW-1:0] Reg_Out;
  logic          N;
  logic          Z;
  logic          C;

  modport master (
    output In_Valid, W_En, W_Adr, R_Adr, S_Adr, S_Sel, DS, ALU_OP,
    input  Out_Valid, Alu_Out, Reg_Out, N, Z, C
  );

  modport slave (
    input  In_Valid, W_En, W_Adr, R_Adr, S_Adr, S_Sel, DS, ALU_OP,
    output Out_Valid, Alu_Out, Reg_Out, N, Z, C
  );

endinterface

// File: rtl/integer_datapath_pipe_reg_file.sv
// Register file: one synchronous write port, two combinational read ports,
// synchronous active-high reset clears every entry.
module reg_file_p #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    we_i,
  input  logic [$clog2(NREG)-1:0] waddr_i,
  input  logic [DW-1:0]           wdata_i,
  input  logic [$clog2(NREG)-1:0] raddr_a_i,
  output logic [DW-1:0]           rdata_a_o,
  input  logic [$clog2(NREG)-1:0] raddr_b_i,
  output logic [DW-1:0]           rdata_b_o
);

  logic [DW-1:0] mem_q [NREG];

  // Storage update: reset wins over write
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: no bypass, the pipeline forwards around same-edge hazards
  always_comb begin
    rdata_a_o = mem_q[raddr_a_i];
    rdata_b_o = mem_q[raddr_b_i];
  end

endmodule

// File: rtl/integer_datapath_pipe.sv
// 2-stage integer datapath: issue/operand-select -> EX (ALU) -> retire/writeback.
// A single EX->issue bypass removes the only hazard, so nothing ever stalls.
module integer_datapath_pipe
  import integer_dp_pkg::*;
#(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  integer_datapath_pipe_if.slave bus
);

  localparam int unsigned AW = $clog2(NREG);
  localparam logic [DW-1:0] One = {{(DW-1){1'b0}}, 1'b1};

  // EX stage registers
  logic          ex_valid_q;
  logic          ex_wen_q;
  logic [AW-1:0] ex_wadr_q;
  alu_op_t       ex_op_q;
  logic [DW-1:0] ex_r_q;
  logic [DW-1:0] ex_s_q;

  // Retire registers
  logic          out_valid_q;
  logic [DW-1:0] alu_out_q;
  logic [DW-1:0] reg_out_q;
  logic          n_q;
  logic          z_q;
  logic          c_q;

  // Combinational signals
  logic [DW-1:0] rf_r;
  logic [DW-1:0] rf_s;
  logic [DW-1:0] r_op;
  logic [DW-1:0] s_op;
  logic [DW-1:0] alu_y;
  logic          alu_c;
  logic [DW:0]   alu_ext;
  logic          fwd_r;
  logic          fwd_s;
  logic          rf_we;

  assign rf_we = ex_valid_q & ex_wen_q;

  reg_file_p #(
    .DW   (DW),
    .NREG (NREG)
  ) u_reg_file (
    .clk_i     (Clk),
    .reset_i   (Reset),
    .we_i      (rf_we),
    .waddr_i   (ex_wadr_q),
    .wdata_i   (alu_y),
    .raddr_a_i (bus.R_Adr),
    .rdata_a_o (rf_r),
    .raddr_b_i (bus.S_Adr),
    .rdata_b_o (rf_s)
  );

  // Operand select with EX->issue forwarding; DS always bypasses the regfile
  always_comb begin
    fwd_r = rf_we && (ex_wadr_q == bus.R_Adr);
    fwd_s = rf_we && (ex_wadr_q == bus.S_Adr);
    r_op  = fwd_r ? alu_y : rf_r;
    if (bus.S_Sel) begin
      s_op = bus.DS;
    end else begin
      s_op = fwd_s ? alu_y : rf_s;
    end
  end

  // ALU on EX operands; C carries carry/borrow/shifted-out bit, else 0
  always_comb begin
    alu_y   = '0;
    alu_c   = 1'b0;
    alu_ext = '0;
    case (ex_op_q)
      OP_PASS_S: alu_y = ex_s_q;
      OP_PASS_R: alu_y = ex_r_q;
      OP_ADD: begin
        alu_ext = {1'b0, ex_r_q} + {1'b0, ex_s_q};
        alu_y   = alu_ext[DW-1:0];
        alu_c   = alu_ext[DW];
      end
      OP_SUB: begin
        // Bit DW of the extended difference is set exactly when R < S
        alu_ext = {1'b0, ex_r_q} - {1'b0, ex_s_q};
        alu_y   = alu_ext[DW-1:0];
        alu_c   = alu_ext[DW];
      end
      OP_INC: begin
        alu_ext = {1'b0, ex_s_q} + {1'b0, One};
        alu_y   = alu_ext[DW-1:0];
        alu_c   = alu_ext[DW];
      end
      OP_DEC: begin
        alu_y = ex_s_q - One;
        alu_c = (ex_s_q == '0);
      end
      OP_AND: alu_y = ex_r_q & ex_s_q;
      OP_OR:  alu_y = ex_r_q | ex_s_q;
      OP_XOR: alu_y = ex_r_q ^ ex_s_q;
      OP_NOT: alu_y = ~ex_s_q;
      OP_SHL: begin
        alu_y = {ex_s_q[DW-2:0], 1'b0};
        alu_c = ex_s_q[DW-1];
      end
      OP_SHR: begin
        alu_y = {1'b0, ex_s_q[DW-1:1]};
        alu_c = ex_s_q[0];
      end
      OP_ASR: begin
        alu_y = {ex_s_q[DW-1], ex_s_q[DW-1:1]};
        alu_c = ex_s_q[0];
      end
      default: begin
        alu_y = '0;
        alu_c = 1'b0;
      end
    endcase
  end

  // Issue: capture operands into EX; bubbles only clear the valid bit
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_valid_q <= 1'b0;
      ex_wen_q   <= 1'b0;
      ex_wadr_q  <= '0;
      ex_op_q    <= OP_PASS_S;
      ex_r_q     <= '0;
      ex_s_q     <= '0;
    end else if (bus.In_Valid) begin
      ex_valid_q <= 1'b1;
      ex_wen_q   <= bus.W_En;
      ex_wadr_q  <= bus.W_Adr;
      ex_op_q    <= bus.ALU_OP;
      ex_r_q     <= r_op;
      ex_s_q     <= s_op;
    end else begin
      ex_valid_q <= 1'b0;
    end
  end

  // Retire: results and flags hold across bubbles
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      reg_out_q   <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
    end else if (ex_valid_q) begin
      out_valid_q <= 1'b1;
      alu_out_q   <= alu_y;
      reg_out_q   <= ex_r_q;
      n_q         <= alu_y[DW-1];
      z_q         <= (alu_y == '0);
      c_q         <= alu_c;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.Out_Valid = out_valid_q;
  assign bus.Alu_Out   = alu_out_q;
  assign bus.Reg_Out   = reg_out_q;
  assign bus.N         = n_q;
  assign bus.Z         = z_q;
  assign bus.C         = c_q;

endmodule
